// File: rtl/cu_pkg.sv
// Shared opcode values, sequencer state encoding and instruction classes for the
// Mini-SRC control unit.
package cu_pkg;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_MUL  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_BR   = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_JAL  = 5'b10101;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

   typedef enum logic [4:0] {
      CL_RR, CL_IMM, CL_UN, CL_LD, CL_LDI, CL_ST, CL_BR, CL_JR, CL_JAL,
      CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_MULDIV, CL_NOP, CL_HALT, CL_ILL
   } iclass_t;

   // Final execute step of each class; the sequencer returns to T0 after it.
   // mul/div keep two idle steps so the multi-cycle unit can settle into Z.
   function automatic state_t last_step(input iclass_t c);
      case (c)
         CL_UN, CL_JAL:          return T4;
         CL_RR, CL_IMM, CL_LDI:  return T5;
         CL_BR, CL_MULDIV:       return T6;
         CL_LD, CL_ST:           return T7;
         default:                return T3;
      endcase
   endfunction

endpackage

// File: rtl/cu_decode.sv
// Opcode to instruction-class decoder. mul/div decode as a real class only when
// CU_MULDIV_EN is defined; otherwise they fall into the illegal class.
module cu_decode
   import cu_pkg::*;
(
   input  logic [4:0] opcode_i,
   output iclass_t    iclass_o
);

   always_comb begin
      iclass_o = CL_ILL;
      case (opcode_i)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
         OP_ROL, OP_SHR, OP_SHRA, OP_SHL:        iclass_o = CL_RR;
         OP_ADDI, OP_ANDI, OP_ORI:               iclass_o = CL_IMM;
         OP_NEG, OP_NOT:                         iclass_o = CL_UN;
         OP_LD:                                  iclass_o = CL_LD;
         OP_LDI:                                 iclass_o = CL_LDI;
         OP_ST:                                  iclass_o = CL_ST;
         OP_BR:                                  iclass_o = CL_BR;
         OP_JR:                                  iclass_o = CL_JR;
         OP_JAL:                                 iclass_o = CL_JAL;
         OP_IN:                                  iclass_o = CL_IN;
         OP_OUT:                                 iclass_o = CL_OUT;
         OP_MFHI:                                iclass_o = CL_MFHI;
         OP_MFLO:                                iclass_o = CL_MFLO;
         OP_NOP:                                 iclass_o = CL_NOP;
         OP_HALT:                                iclass_o = CL_HALT;
`ifdef CU_MULDIV_EN
         OP_MUL, OP_DIV:                         iclass_o = CL_MULDIV;
`endif
         default:                                iclass_o = CL_ILL;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Mini-SRC fetch/decode/execute sequencer driving every datapath strobe.
// Build option: CU_MULDIV_EN adds the mul/div execute sequence.
//  state | meaning
//  RST   | held in reset, all strobes low, ALU code ADD
//  T0-T2 | instruction fetch (PC->MAR, memory->MDR, MDR->IR)
//  T3-T7 | execute steps of the decoded instruction class
//  HALT  | stopped, run low, left only through clear
module control_unit
   import cu_pkg::*;
#(
   parameter int OP_LSB = 27,
   parameter int ALU_W  = 5
) (
   input  logic             clock,
   input  logic             clear,
   input  logic [31:0]      ir,
   input  logic             con_ff,
   output logic             PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin,
   output logic             ZLOin, ZLOout, ZHIout, Cout, BAout,
   output logic             Gra, Grb, Grc, Rin, Rout, R15in,
   output logic             read, write, RAMenable, conin, OutPortenable, PortInout,
   output logic [ALU_W-1:0] aluControl,
   output logic             run,
   output logic             illegal
);

   state_t          state_q, state_d;
   iclass_t         iclass;
   state_t          last;
   logic [4:0]      opcode;
   logic [ALU_W-1:0] alu_op;
   logic            unused_ir;

   assign opcode    = ir[OP_LSB+4:OP_LSB];
   assign alu_op    = ALU_W'(opcode);
   assign unused_ir = ^ir[OP_LSB-1:0];
   assign last      = last_step(iclass);

   cu_decode u_decode (
      .opcode_i (opcode),
      .iclass_o (iclass)
   );

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) state_q <= RST;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RST:     state_d = T0;
         T0:      state_d = T1;
         T1:      state_d = T2;
         T2:      state_d = T3;
         T3:      state_d = (iclass == CL_HALT) ? HALT : ((last == T3) ? T0 : T4);
         T4:      state_d = (last == T4) ? T0 : T5;
         T5:      state_d = (last == T5) ? T0 : T6;
         T6:      state_d = (last == T6) ? T0 : T7;
         T7:      state_d = T0;
         HALT:    state_d = HALT;
         default: state_d = RST;
      endcase
   end

   always_comb begin
      {PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin} = '0;
      {ZLOin, ZLOout, ZHIout, Cout, BAout}                  = '0;
      {Gra, Grb, Grc, Rin, Rout, R15in}                     = '0;
      {read, write, RAMenable, conin, OutPortenable, PortInout} = '0;
      aluControl = ALU_W'(OP_ADD);
      illegal    = 1'b0;
      run        = (state_q != RST) && (state_q != HALT);
      case (state_q)
         T0: {PCout, MARin, IncPC} = '1;
         T1: {read, RAMenable, MDRin} = '1;
         T2: {MDRout, IRin} = '1;
         T3: case (iclass)
               CL_RR, CL_IMM:         {Grb, Rout, Yin} = '1;
               CL_UN:                 begin {Grb, Rout, ZLOin} = '1; aluControl = alu_op; end
               CL_LDI, CL_LD, CL_ST:  {Grb, BAout, Yin} = '1;
               CL_BR:                 {Gra, Rout, conin} = '1;
               CL_JR:                 {Gra, Rout, PCin} = '1;
               CL_JAL:                {PCout, R15in} = '1;
               CL_IN:                 {PortInout, Gra, Rin} = '1;
               CL_OUT:                {Gra, Rout, OutPortenable} = '1;
               CL_MFHI:               {ZHIout, Gra, Rin} = '1;
               CL_MFLO:               {ZLOout, Gra, Rin} = '1;
               CL_MULDIV:             {Gra, Rout, Yin} = '1;
               CL_ILL:                illegal = 1'b1;
               default:               ;
            endcase
         T4: case (iclass)
               CL_RR:                 begin {Grc, Rout, ZLOin} = '1; aluControl = alu_op; end
               CL_IMM:                begin {Cout, ZLOin} = '1; aluControl = alu_op; end
               CL_UN:                 {ZLOout, Gra, Rin} = '1;
               CL_LDI, CL_LD, CL_ST:  {Cout, ZLOin} = '1;
               CL_BR:                 {PCout, Yin} = '1;
               CL_JAL:                {Gra, Rout, PCin} = '1;
               CL_MULDIV:             begin {Grb, Rout, ZLOin} = '1; aluControl = alu_op; end
               default:               ;
            endcase
         T5: case (iclass)
               CL_RR, CL_IMM, CL_LDI: {ZLOout, Gra, Rin} = '1;
               CL_LD, CL_ST:          {ZLOout, MARin} = '1;
               CL_BR:                 {Cout, ZLOin} = '1;
               default:               ;
            endcase
         // A branch not taken leaves T6 as an idle step.
         T6: case (iclass)
               CL_LD:                 {read, RAMenable, MDRin} = '1;
               CL_ST:                 {Gra, Rout, MDRin} = '1;
               CL_BR:                 if (con_ff) {ZLOout, PCin} = '1;
               default:               ;
            endcase
         T7: case (iclass)
               CL_LD:                 {MDRout, Gra, Rin} = '1;
               CL_ST:                 {write, RAMenable} = '1;
               default:               ;
            endcase
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit against a per-instruction step model.
module tb_control_unit;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] ir = '0;
   logic        con_ff = 1'b0;
   logic PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin;
   logic ZLOin, ZLOout, ZHIout, Cout, BAout;
   logic Gra, Grb, Grc, Rin, Rout, R15in;
   logic read, write, RAMenable, conin, OutPortenable, PortInout;
   logic [4:0] aluControl;
   logic run, illegal;

   int vectors = 0;
   int miscompares = 0;

   control_unit dut (
      .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff),
      .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
      .ZLOin(ZLOin), .ZLOout(ZLOout), .ZHIout(ZHIout), .Cout(Cout), .BAout(BAout),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .R15in(R15in),
      .read(read), .write(write), .RAMenable(RAMenable), .conin(conin),
      .OutPortenable(OutPortenable), .PortInout(PortInout),
      .aluControl(aluControl), .run(run), .illegal(illegal)
   );

   always #5 clock = ~clock;

   logic [31:0] obs;
   assign obs = {aluControl, run, illegal, PortInout, OutPortenable, conin, RAMenable,
                 write, read, R15in, Rout, Rin, Grc, Grb, Gra, BAout, Cout, ZHIout,
                 ZLOout, ZLOin, Yin, IRin, MDRout, MDRin, MARin, PCin, IncPC, PCout};

   localparam logic [26:0] PCO  = 27'd1 << 0,  INC  = 27'd1 << 1,  PCI  = 27'd1 << 2;
   localparam logic [26:0] MARI = 27'd1 << 3,  MDRI = 27'd1 << 4,  MDRO = 27'd1 << 5;
   localparam logic [26:0] IRI  = 27'd1 << 6,  YI   = 27'd1 << 7,  ZI   = 27'd1 << 8;
   localparam logic [26:0] ZO   = 27'd1 << 9,  ZHO  = 27'd1 << 10, CO   = 27'd1 << 11;
   localparam logic [26:0] BAO  = 27'd1 << 12, GRA  = 27'd1 << 13, GRB  = 27'd1 << 14;
   localparam logic [26:0] GRC  = 27'd1 << 15, RI   = 27'd1 << 16, RO   = 27'd1 << 17;
   localparam logic [26:0] R15I = 27'd1 << 18, RD   = 27'd1 << 19, WR   = 27'd1 << 20;
   localparam logic [26:0] RAM  = 27'd1 << 21, CONI = 27'd1 << 22, OPE  = 27'd1 << 23;
   localparam logic [26:0] PIO  = 27'd1 << 24, ILL  = 27'd1 << 25, RUN  = 27'd1 << 26;
   localparam logic [26:0] BUS  = PCO | ZO | ZHO | MDRO | RO | CO | BAO | PIO;
   localparam logic [31:0] IDLE_V = {5'd3, 27'd0};

`ifdef CU_MULDIV_EN
   localparam bit MULDIV = 1'b1;
`else
   localparam bit MULDIV = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h", tag, got, want);
      end
   endtask

   function automatic bit is_muldiv(input logic [4:0] op);
      return MULDIV && (op == 5'd15 || op == 5'd16);
   endfunction

   // Cycles from T0 to the return to T0, per the instruction latency table.
   function automatic int latency(input logic [4:0] op);
      if (is_muldiv(op)) return 7;
      case (op) inside
         [5'd3:5'd14], 5'd1:      return 6;
         5'd17, 5'd18, 5'd21:     return 5;
         5'd19:                   return 7;
         5'd0, 5'd2:              return 8;
         default:                 return 4;
      endcase
   endfunction

   // Expected {aluControl, run, illegal, strobes} for step k of instruction op.
   function automatic logic [31:0] model(input logic [4:0] op, input int k, input bit con);
      logic [26:0] s;
      logic [4:0]  alu;
      s   = RUN;
      alu = 5'd3;
      if (k == 0)      s |= PCO | MARI | INC;
      else if (k == 1) s |= RD | RAM | MDRI;
      else if (k == 2) s |= MDRO | IRI;
      else if (is_muldiv(op)) begin
         if (k == 3) s |= GRA | RO | YI;
         if (k == 4) begin s |= GRB | RO | ZI; alu = op; end
      end else begin
         case (op) inside
            [5'd3:5'd14]: begin
               if (k == 3) s |= GRB | RO | YI;
               if (k == 4) begin s |= (op <= 5'd11) ? (GRC | RO | ZI) : (CO | ZI); alu = op; end
               if (k == 5) s |= ZO | GRA | RI;
            end
            5'd17, 5'd18: begin
               if (k == 3) begin s |= GRB | RO | ZI; alu = op; end
               if (k == 4) s |= ZO | GRA | RI;
            end
            5'd0, 5'd1, 5'd2: begin
               if (k == 3) s |= GRB | BAO | YI;
               if (k == 4) s |= CO | ZI;
               if (k == 5) s |= (op == 5'd1) ? (ZO | GRA | RI) : (ZO | MARI);
               if (k == 6) s |= (op == 5'd0) ? (RD | RAM | MDRI) : (GRA | RO | MDRI);
               if (k == 7) s |= (op == 5'd0) ? (MDRO | GRA | RI) : (WR | RAM);
            end
            5'd19: begin
               if (k == 3) s |= GRA | RO | CONI;
               if (k == 4) s |= PCO | YI;
               if (k == 5) s |= CO | ZI;
               if (k == 6 && con) s |= ZO | PCI;
            end
            5'd20: s |= GRA | RO | PCI;
            5'd21: s |= (k == 3) ? (PCO | R15I) : (GRA | RO | PCI);
            5'd22: s |= PIO | GRA | RI;
            5'd23: s |= GRA | RO | OPE;
            5'd24: s |= ZHO | GRA | RI;
            5'd25: s |= ZO | GRA | RI;
            5'd26, 5'd27: ;
            default: s |= ILL;
         endcase
      end
      return {alu, s};
   endfunction

   // Entry and exit: at a negedge with the DUT sitting in T0.
   task automatic run_instr(input logic [4:0] op, input bit con, input int abort_k);
      int lat = latency(op);
      ir     = {op, 27'($urandom)};
      con_ff = con;
      for (int k = 0; k < lat; k++) begin
         check($sformatf("op%02h_step%0d", op, k), obs, model(op, k, con));
         check("bus_excl", {31'd0, $countones(obs[26:0] & BUS) <= 1}, 32'd1);
         if (k == abort_k) begin
            #1 clear = 1'b0;
            #1 check($sformatf("abort_op%02h_step%0d", op, k), obs, IDLE_V);
            @(negedge clock);
            clear = 1'b1;
            @(negedge clock);
            return;
         end
         @(negedge clock);
      end
      if (op == 5'd27) begin
         for (int c = 0; c < 20; c++) begin
            check($sformatf("halt_c%0d", c), obs, IDLE_V);
            @(negedge clock);
         end
         clear = 1'b0;
         #1 check("halt_clear", obs, IDLE_V);
         @(negedge clock);
         clear = 1'b1;
         @(negedge clock);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] op;
      int         ab;
      repeat (2) begin
         @(negedge clock);
         check("reset", obs, IDLE_V);
      end
      clear = 1'b1;
      @(negedge clock);

      run_instr(5'd3,  1'b0, -1);   // add
      run_instr(5'd0,  1'b0, -1);   // ld
      run_instr(5'd19, 1'b0, -1);   // br not taken
      run_instr(5'd19, 1'b1, -1);   // br taken
      run_instr(5'd2,  1'b0, 4);    // st aborted in T4
      run_instr(5'd2,  1'b1, -1);   // st complete
      run_instr(5'd30, 1'b0, -1);   // undefined opcode
      run_instr(5'd16, 1'b0, -1);   // mul
      run_instr(5'd15, 1'b1, -1);   // div
      run_instr(5'd27, 1'b0, -1);   // halt
      run_instr(5'd12, 1'b0, -1);   // addi

      for (int n = 0; n < 400; n++) begin
         op = 5'($urandom_range(0, 31));
         if (op == 5'd27 && $urandom_range(0, 3) != 0) op = 5'd26;
         ab = -1;
         if (op != 5'd27 && $urandom_range(0, 9) == 0)
            ab = int'($urandom_range(0, latency(op) - 1));
         run_instr(op, 1'($urandom), ab);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
